// File: rtl/pc_fetch_unit.sv
// Fetch PC register with redirect > stall > BTB prediction > sequential next-PC selection.
// Next PC lands one cycle after selection; stall holds the PC, redirect overrides stall.
module pc_fetch_unit #(
  parameter int                XLEN         = 32,
  parameter logic [XLEN-1:0]   RESET_VECTOR = 32'h0040_0000,
  parameter int                BTB_ENTRIES  = 8,
  parameter int                INC          = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_addr,
  input  logic            update_valid,
  input  logic [XLEN-1:0] update_pc,
  input  logic [XLEN-1:0] update_target,
  input  logic            update_taken,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target
);

  localparam int              IDX   = $clog2(BTB_ENTRIES);
  localparam int              TAGW  = XLEN - IDX - 2;
  localparam logic [XLEN-1:0] INC_V = XLEN'(INC);

  logic [BTB_ENTRIES-1:0] btb_valid;
  logic [TAGW-1:0]        btb_tag    [BTB_ENTRIES];
  logic [XLEN-1:0]        btb_target [BTB_ENTRIES];

  logic [IDX-1:0]  look_idx;
  logic [TAGW-1:0] look_tag;
  logic [IDX-1:0]  upd_idx;
  logic [TAGW-1:0] upd_tag;
  logic [XLEN-1:0] next_pc;
  logic            unused_bits;

  assign look_idx = pc[IDX+1:2];
  assign look_tag = pc[XLEN-1:IDX+2];
  assign upd_idx  = update_pc[IDX+1:2];
  assign upd_tag  = update_pc[XLEN-1:IDX+2];

  // Word offset bits never address the BTB and are discarded on redirect.
  assign unused_bits = ^{redirect_addr[1:0], update_pc[1:0]};

  assign pred_taken  = btb_valid[look_idx] && (btb_tag[look_idx] == look_tag);
  assign pred_target = pred_taken ? btb_target[look_idx] : '0;

  always_comb begin
    next_pc = pc + INC_V;
    if (pred_taken) begin
      next_pc = pred_target;
    end
    if (stall) begin
      next_pc = pc;
    end
    if (redirect_valid) begin
      next_pc = {redirect_addr[XLEN-1:2], 2'b00};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc       <= RESET_VECTOR;
      pc_valid <= 1'b0;
    end else begin
      pc       <= next_pc;
      pc_valid <= 1'b1;
    end
  end

  // Only the valid bits need reset; tag/target contents are ignored while invalid.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      btb_valid <= '0;
    end else if (update_valid) begin
      if (update_taken) begin
        btb_valid[upd_idx] <= 1'b1;
      end else if (btb_tag[upd_idx] == upd_tag) begin
        btb_valid[upd_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (update_valid && update_taken) begin
      btb_tag[upd_idx]    <= upd_tag;
      btb_target[upd_idx] <= update_target;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: sequencing, stall/redirect priority, BTB train/alias/invalidate, wrap, async reset.
module tb_pc_fetch_unit;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        update_valid;
  logic [31:0] update_pc;
  logic [31:0] update_target;
  logic        update_taken;
  logic [31:0] pc;
  logic        pc_valid;
  logic        pred_taken;
  logic [31:0] pred_target;

  int checks = 0;
  int errors = 0;

  pc_fetch_unit #(
    .XLEN(32), .RESET_VECTOR(32'h0040_0000), .BTB_ENTRIES(8), .INC(4)
  ) dut (
    .clock(clock), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .update_valid(update_valid), .update_pc(update_pc),
    .update_target(update_target), .update_taken(update_taken),
    .pc(pc), .pc_valid(pc_valid), .pred_taken(pred_taken), .pred_target(pred_target)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("%s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    stall = 0; redirect_valid = 0; redirect_addr = 0;
    update_valid = 0; update_pc = 0; update_target = 0; update_taken = 0;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    #12;
    chk("rst_pc", pc, 32'h0040_0000);
    chk("rst_pc_valid", {31'd0, pc_valid}, 32'd0);
    chk("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
    chk("rst_pred_target", pred_target, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Free-running sequential fetch
    step(); chk("seq1_pc", pc, 32'h0040_0004);
    chk("seq1_pc_valid", {31'd0, pc_valid}, 32'd1);
    step(); chk("seq2_pc", pc, 32'h0040_0008);
    step(); chk("seq3_pc", pc, 32'h0040_000C);

    // Back to 0x...08, stall one edge, then stall+redirect (redirect wins, aligned)
    redirect_valid = 1; redirect_addr = 32'h0040_0008;
    step(); chk("redir_pc", pc, 32'h0040_0008);
    redirect_valid = 0; stall = 1;
    step(); chk("stall_hold", pc, 32'h0040_0008);
    redirect_valid = 1; redirect_addr = 32'h0040_0103;
    step(); chk("stall_redir", pc, 32'h0040_0100);
    idle();
    step(); chk("after_redir_seq", pc, 32'h0040_0104);

    // Train 0x10 -> 0x40 while restarting fetch at the reset vector
    redirect_valid = 1; redirect_addr = 32'h0040_0000;
    update_valid = 1; update_pc = 32'h0040_0010; update_target = 32'h0040_0040; update_taken = 1;
    step(); idle();
    chk("train_pc", pc, 32'h0040_0000);
    chk("miss_pred", {31'd0, pred_taken}, 32'd0);
    step(); step(); step(); step();
    chk("hit_pc", pc, 32'h0040_0010);
    chk("hit_pred", {31'd0, pred_taken}, 32'd1);
    chk("hit_target", pred_target, 32'h0040_0040);
    step(); chk("pred_applied", pc, 32'h0040_0040);

    // Same-index same-cycle update: lookup still sees old (empty) entry
    update_valid = 1; update_pc = 32'h0040_0040; update_target = 32'h0040_0080; update_taken = 1;
    #1; chk("same_cycle_old", {31'd0, pred_taken}, 32'd0);
    step(); idle();
    chk("same_cycle_next", pc, 32'h0040_0044);

    // Alias not-taken update must not invalidate; matching one must
    redirect_valid = 1; redirect_addr = 32'h0040_0010;
    update_valid = 1; update_pc = 32'h0040_0030; update_taken = 0;
    step(); idle();
    chk("alias_pc", pc, 32'h0040_0010);
    chk("alias_keep", {31'd0, pred_taken}, 32'd1);
    stall = 1;
    update_valid = 1; update_pc = 32'h0040_0010; update_taken = 0;
    step(); idle();
    chk("inval_stall_pc", pc, 32'h0040_0010);
    chk("inval_pred", {31'd0, pred_taken}, 32'd0);
    chk("inval_target", pred_target, 32'd0);
    step(); chk("inval_seq", pc, 32'h0040_0014);

    // Repopulate, reach 0x40, then async reset mid-cycle
    redirect_valid = 1; redirect_addr = 32'h0040_0010;
    update_valid = 1; update_pc = 32'h0040_0010; update_target = 32'h0040_0040; update_taken = 1;
    step(); idle();
    chk("retrain_pred", {31'd0, pred_taken}, 32'd1);
    step(); chk("retrain_pc", pc, 32'h0040_0040);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_pc", pc, 32'h0040_0000);
    chk("async_rst_valid", {31'd0, pc_valid}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    redirect_valid = 1; redirect_addr = 32'h0040_0010;
    step(); idle();
    chk("post_rst_pc", pc, 32'h0040_0010);
    chk("post_rst_pred", {31'd0, pred_taken}, 32'd0);
    chk("post_rst_valid", {31'd0, pc_valid}, 32'd1);

    // Wrap-around from the top of the address space
    redirect_valid = 1; redirect_addr = 32'hFFFF_FFFE;
    step(); idle();
    chk("wrap_top", pc, 32'hFFFF_FFFC);
    step(); chk("wrap_zero", pc, 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Parametrised program-counter and next-fetch-address generator for the front of the RISC-V pipeline. It holds the fetch PC and selects the next PC from a pipeline redirect, a stall hold, a direct-mapped branch target buffer (BTB) prediction, or the sequential increment. It sits between the IF stage's instruction memory address and the EX stage's branch resolution. It replaces the fixed-width, non-predicting program counter.

## Interface
Parameters:
- XLEN, 32, width of PC and addresses
- RESET_VECTOR, 32'h0040_0000, PC value loaded on reset
- BTB_ENTRIES, 8, BTB depth; power of two, minimum 2
- INC, 4, sequential increment in bytes

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- stall  in  1  hold PC this cycle
- redirect_valid  in  1  EX-stage redirect (mispredict or taken jump/branch)
- redirect_addr  in  XLEN  redirect target
- update_valid  in  1  BTB training write from EX
- update_pc  in  XLEN  PC of the resolved branch
- update_target  in  XLEN  resolved target
- update_taken  in  1  1 = taken (install), 0 = not taken (invalidate on match)
- pc  out  XLEN  current fetch PC
- pc_valid  out  1  pc is a real fetch address
- pred_taken  out  1  BTB hit on current pc
- pred_target  out  XLEN  predicted target (0 when no hit)

## Operation
- Reset (reset=0, asynchronous): pc=RESET_VECTOR, pc_valid=0, all BTB valid bits cleared. pred_taken=0 and pred_target=0 follow from the cleared BTB.
- pc_valid goes to 1 on the first rising edge after reset deasserts and stays 1 until the next reset.
- Next-PC priority, evaluated each edge:
  1. redirect_valid=1: next = redirect_addr with bits [1:0] forced to 0. This wins over stall.
  2. stall=1: next = pc.
  3. pred_taken=1: next = pred_target.
  4. Otherwise: next = pc + INC, modulo 2^XLEN. 32'hFFFF_FFFC wraps to 0.
- Until pc_valid is 1, the first edge after reset still applies the rules above. A fetch is issued from RESET_VECTOR.
- BTB organisation:
  - Direct-mapped, BTB_ENTRIES entries.
  - index = addr[IDX+1:2], where IDX = log2(BTB_ENTRIES).
  - tag = addr[XLEN-1:IDX+2].
  - Each entry holds valid, tag and target.
- Lookup is combinational on pc. Hit = entry valid and tag equal. pred_target = entry target on a hit, else 0.
- Update, on the rising edge when update_valid=1:
  - update_taken=1: write valid=1, tag and target, overwriting any aliasing entry.
  - update_taken=0: clear valid only if the stored tag matches update_pc. Otherwise no change.
- Update and lookup of the same index in the same cycle: lookup returns the pre-update contents. The new contents are visible from the next cycle.
- The BTB updates regardless of stall and redirect_valid.

## Timing
- Redirect latency: 1 cycle. pc equals the aligned redirect_addr after the edge where redirect_valid=1.
- Stall: pc is unchanged across every edge where stall=1 and redirect_valid=0.
- Prediction is applied at the edge following the cycle in which pc hits.
- Training-to-use latency: 1 cycle.
- Reset asserted mid-operation: all outputs take their reset values immediately, without waiting for a clock edge. Any in-flight redirect or update is discarded.

## Test plan
- Reset then 3 free-running edges, no inputs: pc sequence 0x0040_0000, 0x0040_0004, 0x0040_0008, 0x0040_000C. pc_valid=0 before the first edge, 1 after it.
- stall=1 for 2 cycles at pc=0x0040_0008, with redirect_valid=1 and addr=0x0040_0103 in the second cycle: pc holds for 1 edge, then becomes 0x0040_0100.
- Train: update_pc=0x0040_0010, target=0x0040_0040, taken=1. Then run from reset: pc reaches 0x0040_0010 with pred_taken=1 and pred_target=0x0040_0040. The next pc is 0x0040_0040.
- Aliasing and invalidate (BTB_ENTRIES=8):
  - Install a taken entry at 0x0040_0010.
  - Not-taken update at 0x0040_0030 (same index, different tag): pred_taken stays 1 at 0x0040_0010.
  - Not-taken update at 0x0040_0010: pred_taken becomes 0.
- Wrap: redirect to 0xFFFF_FFFC, then 1 edge: pc=0x0000_0000.
- Assert reset between edges while pc=0x0040_0040 and the BTB is populated: pc is immediately 0x0040_0000 with pc_valid=0. After release, the previously trained PC gives pred_taken=0.
